// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store width codes
// and the responder FSM state encoding.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the byte/halfword addressed by off
// out of a 32-bit word and sign/zero-extends it per funct3. Zero latency.
module load_formatter
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = word[7:0];
    case (off)
      2'd0: sel_b = word[7:0];
      2'd1: sel_b = word[15:8];
      2'd2: sel_b = word[23:16];
      2'd3: sel_b = word[31:24];
      default: sel_b = word[7:0];
    endcase
    sel_h = off[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:   data = {{24{sel_b[7]}}, sel_b};
      F3_LBU:  data = {24'd0, sel_b};
      F3_LH:   data = {{16{sel_h[15]}}, sel_h};
      F3_LHU:  data = {16'd0, sel_h};
      F3_LW:   data = word;
      // reserved codes fall through with the raw word
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked fixed-latency data-memory target: one request in flight, byte-masked stores, formatted loads.
// Response held until rsp_ready; optional misalignment checking with `DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   fmt;
  logic          accept;
  logic          misaligned;
  logic          unused_addr;

  assign idx         = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];
  assign word        = mem[idx];
  assign accept      = req_valid && req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (req_we)
      misaligned = (req_funct3 == F3_SH && req_addr[0]) ||
                   (req_funct3 == F3_SW && req_addr[1:0] != 2'b00);
    else
      misaligned = ((req_funct3 == F3_LH || req_funct3 == F3_LHU) && req_addr[0]) ||
                   (req_funct3 == F3_LW && req_addr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  // Formatting happens at acceptance; the registered result is what the response holds.
  load_formatter u_fmt (
    .word   (word),
    .funct3 (req_funct3),
    .off    (req_addr[1:0]),
    .data   (fmt)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid) state_nxt = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt == CW'(1)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = reset;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= CW'(LATENCY - 1);
      rdata_q <= (req_we || misaligned) ? 32'd0 : fmt;
      err_q   <= misaligned;
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
    end
  end

  // The array has no reset; read above sees the pre-write value.
  always_ff @(posedge clk) begin
    if (accept && req_we && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (LATENCY=2, DEPTH=256).
module tb_dmem_responder;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_pass  = 0;
  int n_total = 0;
  logic [32:0] sb[$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [3:0] mask, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    logic [32:0] e;
    sb.push_back({exp_err, exp_rdata});
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_funct3 = f3; req_wmask = mask; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk({tag, " accept"}, {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(n), 32'(LATENCY - 1));
    chk({tag, " rdata"}, rsp_rdata, e[31:0]);
    chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, e[32]});
    if (rsp_ready) step();
  endtask

  initial begin
    logic [31:0] held;
    logic        mis_en;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis_en = 1'b1;
`else
    mis_en = 1'b0;
`endif
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wmask = '0; req_wdata = '0; rsp_ready = 1'b1;
    step(); step();
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b1;
    step();
    chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);

    xact("sw10", 1'b1, 32'h10, 3'b010, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 3'b010, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
    xact("lw alias", 1'b0, 32'h10 + 32'(4 * DEPTH), 3'b010, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);

    xact("sw20", 1'b1, 32'h20, 3'b010, 4'hF, 32'h80FF7F01, 32'd0, 1'b0);
    xact("lb23", 1'b0, 32'h23, 3'b000, 4'h0, 32'd0, 32'hFFFFFF80, 1'b0);
    xact("lbu23", 1'b0, 32'h23, 3'b100, 4'h0, 32'd0, 32'h00000080, 1'b0);
    xact("lh20", 1'b0, 32'h20, 3'b001, 4'h0, 32'd0, 32'h00007F01, 1'b0);
    xact("lhu22", 1'b0, 32'h22, 3'b101, 4'h0, 32'd0, 32'h000080FF, 1'b0);
    xact("lb21", 1'b0, 32'h21, 3'b000, 4'h0, 32'd0, 32'h0000007F, 1'b0);

    xact("sw20b", 1'b1, 32'h20, 3'b010, 4'hF, 32'h11223344, 32'd0, 1'b0);
    xact("sb21", 1'b1, 32'h21, 3'b000, 4'b0010, 32'h0000AB00, 32'd0, 1'b0);
    xact("lw20", 1'b0, 32'h20, 3'b010, 4'h0, 32'd0, 32'h1122AB44, 1'b0);

    // Backpressure: response must sit still with req_ready low, and a new request is ignored.
    rsp_ready = 1'b0;
    xact("lw bp", 1'b0, 32'h10, 3'b010, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
    held = rsp_rdata;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010;
    req_wmask = 4'hF; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp rdata", rsp_rdata, held);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp release req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
    xact("lw after bp", 1'b0, 32'h10, 3'b010, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT: the store is committed but no response appears.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010;
    req_wmask = 4'hF; req_wdata = 32'h5;
    chk("sw30 accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("rst-wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst-wait req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst-wait rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst-wait no rsp", {31'd0, rsp_valid}, 32'd0);
    end
    xact("lw30", 1'b0, 32'h30, 3'b010, 4'h0, 32'd0, 32'h00000005, 1'b0);

    // Misalignment handling differs by build.
    xact("sw40", 1'b1, 32'h40, 3'b010, 4'hF, 32'h12345678, 32'd0, 1'b0);
    xact("sw42", 1'b1, 32'h42, 3'b010, 4'hF, 32'hFFFFFFFF, 32'd0, mis_en);
    xact("lw40", 1'b0, 32'h40, 3'b010, 4'h0, 32'd0,
         mis_en ? 32'h12345678 : 32'hFFFFFFFF, 1'b0);
    xact("lh41", 1'b0, 32'h41, 3'b001, 4'h0, 32'd0,
         mis_en ? 32'h00005678 ^ 32'h00005678 : 32'hFFFFFFFF, mis_en);
    xact("rsvd41", 1'b0, 32'h41, 3'b011, 4'h0, 32'd0,
         mis_en ? 32'h12345678 : 32'hFFFFFFFF, 1'b0);
    xact("lhu42", 1'b0, 32'h42, 3'b101, 4'h0, 32'd0,
         mis_en ? 32'h00001234 : 32'h0000FFFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
